// File: rtl/vecshift_col_drain_if.sv
// rtl/vecshift_col_drain_if.sv - signal bundle between the column drain stage, the column and the output consumer
//
// Purpose: groups the drain control, bottom-register sample and output stream signals.
// Modports:
//   slave  - the drain stage (vecshift_col_drain)
//   master - the environment: sequencer/start source, column bottom register, output consumer
// Signals:
//   start          drain request pulse (master -> slave)
//   ready_o        drain stage idle with empty FIFO
//   done           one-cycle pulse when the drain has finished and the FIFO is empty
//   err_timeout    sticky timeout flag
//   confSig        shared confSig of all column registers
//   colData        parallelOut of the bottom register
//   colStatus      {isLast,isData} of the bottom register
//   out_data       FIFO head word
//   out_last       head word is the last word of the column
//   out_valid      FIFO non-empty
//   out_ready      consumer accepts the head word
//   word_cnt       words captured in the current/last drain
//   dbg_clk_enable debug stepping enable
interface vecshift_col_drain_if #(
    parameter int REG_WIDTH = 16,
    parameter int COL_LEN   = 8,
    parameter int CONF_W    = 2
);
    localparam int CNT_W = $clog2(COL_LEN + 1);

    logic                 start;
    logic                 ready_o;
    logic                 done;
    logic                 err_timeout;
    logic [CONF_W-1:0]    confSig;
    logic [REG_WIDTH-1:0] colData;
    logic [1:0]           colStatus;
    logic [REG_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_W-1:0]     word_cnt;
    logic                 dbg_clk_enable;

    modport slave (
        input  start, colData, colStatus, out_ready, dbg_clk_enable,
        output ready_o, done, err_timeout, confSig, out_data, out_last, out_valid, word_cnt
    );

    modport master (
        output start, colData, colStatus, out_ready, dbg_clk_enable,
        input  ready_o, done, err_timeout, confSig, out_data, out_last, out_valid, word_cnt
    );
endinterface

// File: rtl/vecshift_col_drain.sv
// rtl/vecshift_col_drain.sv - vector-shift column drain: confSig sequencer, capture FIFO and output stream
//
// Purpose: sequences one parallel shift of the vecshift_reg column, captures every valid word
// leaving the bottom register into a COL_LEN-deep FIFO and streams it out over valid/ready.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - vecshift_col_drain_if.slave (start/ready_o/done/err_timeout, confSig, colData/colStatus,
//          out_data/out_last/out_valid/out_ready, word_cnt, dbg_clk_enable)
// confSig codes: 0 IDLE, 2 PARALLEL_EN, 3 DISABLE.
module vecshift_col_drain #(
    parameter int DEBUG     = 1,
    parameter int REG_WIDTH = 16,
    parameter int COL_LEN   = 8
) (
    input  logic               clk,
    input  logic               rst,
    vecshift_col_drain_if.slave bus
);
    localparam int VECREG_CONFIG_WIDTH = 2;
    localparam logic [VECREG_CONFIG_WIDTH-1:0] VECREG_IDLE        = 2'd0;
    localparam logic [VECREG_CONFIG_WIDTH-1:0] VECREG_PARALLEL_EN = 2'd2;
    localparam logic [VECREG_CONFIG_WIDTH-1:0] VECREG_DISABLE     = 2'd3;

    localparam int CNT_W = $clog2(COL_LEN + 1);
    localparam int PTR_W = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;
    localparam int TMO_W = $clog2(COL_LEN + 3);

    typedef enum logic [2:0] {
        S_RSTOP,
        S_IDLE,
        S_ARM,
        S_SHIFT,
        S_STOP,
        S_DRAIN
    } state_t;

    state_t                         state_q;
    logic [VECREG_CONFIG_WIDTH-1:0] conf_q;
    logic                           done_q;
    logic                           err_q;
    logic [CNT_W-1:0]               wcnt_q;
    logic [TMO_W-1:0]               cyc_q;

    logic [REG_WIDTH:0]             mem_q [COL_LEN];
    logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic ce;
    logic col_is_data, col_is_last;
    logic fifo_empty, fifo_full;
    logic push, push_ok, pop;

    assign ce          = (DEBUG != 0) ? bus.dbg_clk_enable : 1'b1;
    assign col_is_data = bus.colStatus[0];
    assign col_is_last = bus.colStatus[1];

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(COL_LEN));

    // The column cannot be paused, so a capture is never back-pressured; a push into a full
    // FIFO only survives when a pop frees the slot in the same cycle.
    assign push    = (state_q == S_SHIFT) && col_is_data;
    assign push_ok = push && (!fifo_full || pop);
    assign pop     = !fifo_empty && bus.out_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(COL_LEN - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Drain sequencer. confSig is registered together with the state it belongs to, so it
    // is valid for the whole cycle spent in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RSTOP;
            conf_q  <= VECREG_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
            cyc_q   <= '0;
        end else if (ce) begin
            done_q <= 1'b0;
            case (state_q)
                // RSTOP spends one cycle emitting DISABLE to stop a column that a mid-shift
                // reset left running; conf_q doubles as the "already emitted" flag.
                S_RSTOP: begin
                    if (conf_q == VECREG_DISABLE) begin
                        state_q <= S_IDLE;
                        conf_q  <= VECREG_IDLE;
                    end else begin
                        conf_q  <= VECREG_DISABLE;
                    end
                end
                S_IDLE: begin
                    if (bus.start && fifo_empty) begin
                        state_q <= S_ARM;
                        conf_q  <= VECREG_PARALLEL_EN;
                        wcnt_q  <= '0;
                        err_q   <= 1'b0;
                        cyc_q   <= '0;
                    end
                end
                S_ARM: begin
                    state_q <= S_SHIFT;
                    conf_q  <= VECREG_IDLE;
                end
                S_SHIFT: begin
                    cyc_q <= cyc_q + TMO_W'(1);
                    if (col_is_data && (wcnt_q != CNT_W'(COL_LEN))) begin
                        wcnt_q <= wcnt_q + CNT_W'(1);
                    end
                    if (col_is_data && col_is_last) begin
                        state_q <= S_STOP;
                        conf_q  <= VECREG_DISABLE;
                    end else if (cyc_q == TMO_W'(COL_LEN + 1)) begin
                        // this is the (COL_LEN+2)-th shift cycle without an isLast word
                        err_q   <= 1'b1;
                        state_q <= S_STOP;
                        conf_q  <= VECREG_DISABLE;
                    end
                end
                S_STOP: begin
                    state_q <= S_DRAIN;
                    conf_q  <= VECREG_IDLE;
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    conf_q  <= VECREG_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (ce) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever presented.
    always_ff @(posedge clk) begin
        if (ce && push_ok) begin
            mem_q[wr_ptr_q] <= {col_is_last, bus.colData};
        end
    end

    assign bus.ready_o     = (state_q == S_IDLE) && fifo_empty;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
    assign bus.confSig     = conf_q;
    assign bus.word_cnt    = wcnt_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = mem_q[rd_ptr_q][REG_WIDTH-1:0];
    assign bus.out_last    = mem_q[rd_ptr_q][REG_WIDTH];
endmodule

// File: tb/tb_vecshift_col_drain.sv
// tb/tb_vecshift_col_drain.sv - directed table-driven bench for vecshift_col_drain
`timescale 1ns/1ps
module tb_vecshift_col_drain;
    localparam int RW    = 16;
    localparam int CL    = 8;
    localparam int CW    = 2;
    localparam int NSLOT = CL + 2;
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_PAR  = 2'd2;
    localparam logic [1:0] C_DIS  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vecshift_col_drain_if #(.REG_WIDTH(RW), .COL_LEN(CL), .CONF_W(CW)) bus ();

    vecshift_col_drain #(.DEBUG(1), .REG_WIDTH(RW), .COL_LEN(CL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    int last_pop_cyc = 0;
    logic [RW:0] exp_q[$];

    typedef struct {
        string      name;
        logic [9:0] mask;        // isData per shift slot
        int         last_slot;   // slot carrying isLast, -1 for none
        bit         hold;        // out_ready low until STOP
        bit         shift_start; // pulse start during SHIFT
        int         exp_words;
        int         exp_pops;
        bit         exp_err;
    } vec_t;

    vec_t tv[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] slot_data(input int k);
        return RW'((k + 1) * 17);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side scoreboard: every accepted word is compared with the expected queue.
    always @(negedge clk) begin
        #1;
        if (!rst && bus.out_valid && bus.out_ready && bus.dbg_clk_enable) begin
            pops++;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got 0x%0h expected none", {bus.out_last, bus.out_data});
            end else begin
                check("pop_word", 32'({bus.out_last, bus.out_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", 32'(bus.ready_o), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("conf_arm", 32'(bus.confSig), 32'(C_PAR));
    endtask

    task automatic wait_done(input string name, input int exp_words, input int exp_pops, input bit exp_err);
        int n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got done=0 expected done=1", name);
        end else begin
            check({name, "_word_cnt"}, 32'(bus.word_cnt), 32'(exp_words));
            check({name, "_pops"}, 32'(pops), 32'(exp_pops));
            check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
            check({name, "_err"}, 32'(bus.err_timeout), 32'(exp_err));
            if (exp_pops > 0) check({name, "_done_after_pop"}, 32'(cyc - last_pop_cyc), 32'd2);
            @(negedge clk);
            check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
            check({name, "_ready_after"}, 32'(bus.ready_o), 32'd1);
            check({name, "_word_cnt_hold"}, 32'(bus.word_cnt), 32'(exp_words));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int nslot;
        nslot = (v.last_slot >= 0) ? v.last_slot + 1 : NSLOT;
        exp_q.delete();
        pops = 0;
        for (int k = 0; k < nslot; k++) begin
            if (v.mask[k]) exp_q.push_back({(k == v.last_slot) ? 1'b1 : 1'b0, slot_data(k)});
        end
        wait_ready();
        bus.out_ready = !v.hold;
        pulse_start();
        for (int k = 0; k < nslot; k++) begin
            @(negedge clk);
            check({v.name, "_conf_shift"}, 32'(bus.confSig), 32'(C_IDLE));
            bus.colStatus = {(k == v.last_slot) ? 1'b1 : 1'b0, v.mask[k]};
            bus.colData   = slot_data(k);
            bus.start     = v.shift_start && (k == 3);
        end
        @(negedge clk);
        bus.colStatus = 2'b00;
        bus.colData   = '0;
        bus.start     = 1'b0;
        check({v.name, "_conf_stop"}, 32'(bus.confSig), 32'(C_DIS));
        check({v.name, "_err_stop"}, 32'(bus.err_timeout), 32'(v.exp_err));
        if (v.hold) begin
            check({v.name, "_held_valid"}, 32'(bus.out_valid), 32'd1);
            repeat (3) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            check({v.name, "_drain_start_conf"}, 32'(bus.confSig), 32'(C_IDLE));
            check({v.name, "_drain_ready"}, 32'(bus.ready_o), 32'd0);
            check({v.name, "_drain_done"}, 32'(bus.done), 32'd0);
            check({v.name, "_held_pops"}, 32'(pops), 32'd0);
            bus.out_ready = 1'b1;
        end
        wait_done(v.name, v.exp_words, v.exp_pops, v.exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{"full",    10'h3FF,  7, 1'b0, 1'b1, 8,  8, 1'b0};
        tv[1] = '{"hold",    10'h3FF,  7, 1'b1, 1'b0, 8,  8, 1'b0};
        tv[2] = '{"timeout", 10'h3FF, -1, 1'b0, 1'b0, 8, 10, 1'b1};
        tv[3] = '{"skip",    10'h3EB,  7, 1'b0, 1'b0, 6,  6, 1'b0};
        tv[4] = '{"tmo_nil", 10'h000, -1, 1'b0, 1'b0, 0,  0, 1'b1};

        bus.start          = 1'b0;
        bus.colData        = '0;
        bus.colStatus      = 2'b00;
        bus.out_ready      = 1'b0;
        bus.dbg_clk_enable = 1'b1;

        // reset values and the one-cycle DISABLE after release
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_conf", 32'(bus.confSig), 32'(C_IDLE));
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);
        check("rst_wcnt", 32'(bus.word_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_conf_dis", 32'(bus.confSig), 32'(C_DIS));
        check("rel_ready0", 32'(bus.ready_o), 32'd0);
        @(negedge clk);
        check("rel_conf_idle", 32'(bus.confSig), 32'(C_IDLE));
        check("rel_ready1", 32'(bus.ready_o), 32'd1);

        for (int i = 0; i < 5; i++) run_vec(tv[i]);

        // debug stepping: with dbg_clk_enable low nothing moves
        exp_q.delete();
        pops = 0;
        exp_q.push_back({1'b1, 16'h00AB});
        bus.out_ready = 1'b1;
        wait_ready();
        pulse_start();
        bus.dbg_clk_enable = 1'b0;
        bus.colStatus      = 2'b11;
        bus.colData        = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            check("frz_conf", 32'(bus.confSig), 32'(C_PAR));
            check("frz_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.dbg_clk_enable = 1'b1;
        bus.colStatus      = 2'b00;
        @(negedge clk);
        check("frz_shift_conf", 32'(bus.confSig), 32'(C_IDLE));
        bus.colStatus = 2'b11;
        bus.colData   = 16'h00AB;
        @(negedge clk);
        bus.colStatus = 2'b00;
        check("frz_stop_conf", 32'(bus.confSig), 32'(C_DIS));
        wait_done("frz", 1, 1, 1'b0);

        // reset in the middle of SHIFT with words sitting in the FIFO
        exp_q.delete();
        bus.out_ready = 1'b0;
        wait_ready();
        pulse_start();
        @(negedge clk);
        bus.colStatus = 2'b01;
        bus.colData   = 16'h0011;
        @(negedge clk);
        bus.colData   = 16'h0022;
        @(negedge clk);
        bus.colStatus = 2'b00;
        check("mid_valid", 32'(bus.out_valid), 32'd1);
        check("mid_wcnt", 32'(bus.word_cnt), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_conf", 32'(bus.confSig), 32'(C_IDLE));
        check("mid_rst_wcnt", 32'(bus.word_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_conf_dis", 32'(bus.confSig), 32'(C_DIS));
        @(negedge clk);
        check("mid_rel_conf_idle", 32'(bus.confSig), 32'(C_IDLE));
        check("mid_rel_ready", 32'(bus.ready_o), 32'd1);
        check("mid_rel_valid", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
